eth_tx_counters: RTL and testbench

- Nibble, frame and byte counter block that sits directly upstream of the Tx state machine (eth_txstatem).
- Consumes that machine's State*/Start* strobes and produces the counts and length decodes it branches on: NibCnt, NibCntEq7/15, NibbleMinFl, MaxFrame, TooBig, ExcessiveDefer.
- Also supplies ByteCnt, which the backoff comparator uses to form RandomEqByteCnt.

---
 rtl/eth_tx_counters_pkg.sv | 28 ++
 rtl/eth_sat_cnt16.sv | 21 ++
 rtl/eth_tx_counters.sv | 108 ++++++++++
 tb/tb_eth_tx_counters.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_counters_pkg.sv
// Shared constants, control-pair type and frame-length threshold helper
// for the Ethernet Tx counter block.
package eth_tx_counters_pkg;

  localparam int MAX_DEFER_NIB_DEF = 6071;
  localparam int CRC_NIB_DEF       = 8;
  localparam int SLOT_NIB_LOG2_DEF = 7;

  localparam int PREAMBLE_NIB = 14;
  localparam int SFD_NIB      = 2;
  localparam int ADDR_NIB     = 12;
  localparam int LEN_NIB      = 4;

  typedef struct packed {
    logic clr;
    logic inc;
  } cnt_ctl_t;

  // 2*fl - 1 - (crc_en ? crc_nib : 0), clamped to 0 when it would go negative.
  function automatic logic [15:0] len_thresh(input logic [15:0] fl,
                                             input logic        crc_en,
                                             input logic [4:0]  crc_nib);
    logic [17:0] t;
    t = {1'b0, fl, 1'b0} - 18'd1 - (crc_en ? {13'd0, crc_nib} : 18'd0);
    return t[17] ? 16'd0 : t[15:0];
  endfunction

endpackage

// File: rtl/eth_sat_cnt16.sv
// 16-bit up counter with synchronous clear (priority) and optional
// saturation at all-ones.
module eth_sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  input  logic        sat_en,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 16'd0;
    else if (clear)
      count <= 16'd0;
    else if (inc && !(sat_en && (&count)))
      count <= count + 16'd1;
  end

endmodule

// File: rtl/eth_tx_counters.sv
// Nibble / frame-nibble / byte counters and length decodes that follow the
// Tx state machine strobes; no state of its own beyond the three counters.
module eth_tx_counters
  import eth_tx_counters_pkg::*;
#(
  parameter int MAX_DEFER_NIB = MAX_DEFER_NIB_DEF,
  parameter int CRC_NIB       = CRC_NIB_DEF,
  parameter int SLOT_NIB_LOG2 = SLOT_NIB_LOG2_DEF
) (
  input  logic        MTxClk,
  input  logic        Reset,
  input  logic        StateIdle,
  input  logic        StateIPG,
  input  logic        StatePreamble,
  input  logic        StateSFD,
  input  logic        StateDA,
  input  logic        StateSA,
  input  logic        StateLength,
  input  logic [1:0]  StateData,
  input  logic        StatePAD,
  input  logic        StateFCS,
  input  logic        StateJam,
  input  logic        StateBackOff,
  input  logic        StateDefer,
  input  logic        StartIPG,
  input  logic        StartDefer,
  input  logic        StartPreamble,
  input  logic        StartSFD,
  input  logic        StartDA,
  input  logic        StartSA,
  input  logic        StartLength,
  input  logic        StartFCS,
  input  logic        StartJam,
  input  logic        StartBackoff,
  input  logic [1:0]  StartData,
  input  logic        CrcEn,
  input  logic        HugEn,
  input  logic        ExDfrEn,
  input  logic [15:0] MinFL,
  input  logic [15:0] MaxFL,
  output logic [15:0] NibCnt,
  output logic [15:0] FrmNibCnt,
  output logic [15:0] ByteCnt,
  output logic        NibCntEq7,
  output logic        NibCntEq15,
  output logic        NibbleMinFl,
  output logic        MaxFrame,
  output logic        TooBig,
  output logic        ExcessiveDefer
);

  localparam logic [15:0] DEFER_LIM = 16'(MAX_DEFER_NIB);
  localparam logic [4:0]  CRC_LEN   = 5'(CRC_NIB);

  cnt_ctl_t    nib_ctl, frm_ctl, byte_ctl;
  logic        frame_state;
  logic        slot_tick;
  logic [15:0] min_thr, max_thr, abs_lim;
  logic        unused_start_data1;

  // Data[0]->Data[1] needs no counter action; only Length->Data[0] clears.
  assign unused_start_data1 = StartData[1];

  assign frame_state = StateDA | StateSA | StateLength | (|StateData) |
                       StatePAD | StateFCS;
  assign slot_tick   = StateBackOff & (&NibCnt[SLOT_NIB_LOG2-1:0]);

  always_comb begin
    nib_ctl.clr  = StartIPG | StartDefer | StartPreamble | StartSFD | StartDA |
                   StartSA | StartLength | StartFCS | StartJam | StartBackoff |
                   StateIdle | (StateLength & StartData[0]);
    // Holding at the defer limit keeps ExcessiveDefer asserted while in Defer.
    nib_ctl.inc  = (StateIPG | StatePreamble | StateSFD | frame_state |
                    StateJam | StateBackOff | StateDefer) & ~ExcessiveDefer;
    frm_ctl.clr  = StartSFD;
    frm_ctl.inc  = frame_state;
    byte_ctl.clr = StartSFD | StartBackoff;
    byte_ctl.inc = (frame_state & FrmNibCnt[0]) | slot_tick;
  end

  eth_sat_cnt16 u_nib_cnt (
    .clk(MTxClk), .rst(Reset), .clear(nib_ctl.clr), .inc(nib_ctl.inc),
    .sat_en(1'b0), .count(NibCnt)
  );

  eth_sat_cnt16 u_frm_cnt (
    .clk(MTxClk), .rst(Reset), .clear(frm_ctl.clr), .inc(frm_ctl.inc),
    .sat_en(1'b1), .count(FrmNibCnt)
  );

  eth_sat_cnt16 u_byte_cnt (
    .clk(MTxClk), .rst(Reset), .clear(byte_ctl.clr), .inc(byte_ctl.inc),
    .sat_en(1'b1), .count(ByteCnt)
  );

  assign min_thr = len_thresh(MinFL, CrcEn, CRC_LEN);
  assign max_thr = len_thresh(MaxFL, CrcEn, CRC_LEN);
  assign abs_lim = 16'({MaxFL, 1'b0} - 17'd1);

  assign NibCntEq7      = (NibCnt[6:0] == 7'd7);
  assign NibCntEq15     = (NibCnt[6:0] == 7'd15);
  assign NibbleMinFl    = (FrmNibCnt >= min_thr);
  assign MaxFrame       = ~HugEn & (|StateData) & (FrmNibCnt == max_thr);
  assign TooBig         = ~HugEn & (FrmNibCnt == abs_lim) &
                          ((|StateData) | StatePAD | StateFCS);
  assign ExcessiveDefer = StateDefer & ~ExDfrEn & (NibCnt == DEFER_LIM);

endmodule

// File: tb/tb_eth_tx_counters.sv
// Directed and randomized bench for eth_tx_counters against an arithmetic
// reference model of the counting rules.
module tb_eth_tx_counters;
  import eth_tx_counters_pkg::*;

  logic        MTxClk = 1'b0;
  logic        Reset;
  logic        StateIdle, StateIPG, StatePreamble, StateSFD, StateDA, StateSA, StateLength;
  logic [1:0]  StateData;
  logic        StatePAD, StateFCS, StateJam, StateBackOff, StateDefer;
  logic        StartIPG, StartDefer, StartPreamble, StartSFD, StartDA, StartSA;
  logic        StartLength, StartFCS, StartJam, StartBackoff;
  logic [1:0]  StartData;
  logic        CrcEn, HugEn, ExDfrEn;
  logic [15:0] MinFL, MaxFL;
  logic [15:0] NibCnt, FrmNibCnt, ByteCnt;
  logic        NibCntEq7, NibCntEq15, NibbleMinFl, MaxFrame, TooBig, ExcessiveDefer;

  eth_tx_counters dut (
    .MTxClk(MTxClk), .Reset(Reset),
    .StateIdle(StateIdle), .StateIPG(StateIPG), .StatePreamble(StatePreamble),
    .StateSFD(StateSFD), .StateDA(StateDA), .StateSA(StateSA), .StateLength(StateLength),
    .StateData(StateData), .StatePAD(StatePAD), .StateFCS(StateFCS), .StateJam(StateJam),
    .StateBackOff(StateBackOff), .StateDefer(StateDefer),
    .StartIPG(StartIPG), .StartDefer(StartDefer), .StartPreamble(StartPreamble),
    .StartSFD(StartSFD), .StartDA(StartDA), .StartSA(StartSA), .StartLength(StartLength),
    .StartFCS(StartFCS), .StartJam(StartJam), .StartBackoff(StartBackoff),
    .StartData(StartData), .CrcEn(CrcEn), .HugEn(HugEn), .ExDfrEn(ExDfrEn),
    .MinFL(MinFL), .MaxFL(MaxFL),
    .NibCnt(NibCnt), .FrmNibCnt(FrmNibCnt), .ByteCnt(ByteCnt),
    .NibCntEq7(NibCntEq7), .NibCntEq15(NibCntEq15), .NibbleMinFl(NibbleMinFl),
    .MaxFrame(MaxFrame), .TooBig(TooBig), .ExcessiveDefer(ExcessiveDefer)
  );

  always #5 MTxClk = ~MTxClk;

  int checks = 0;
  int errors = 0;
  int m_nib, m_frm, m_byt;
  int min_at, maxf_at, big_at, exd_at;
  int seen_maxf, seen_big, seen_exd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    {StateIdle, StateIPG, StatePreamble, StateSFD, StateDA, StateSA, StateLength} = '0;
    {StatePAD, StateFCS, StateJam, StateBackOff, StateDefer} = '0;
    StateData = 2'b00;
    {StartIPG, StartDefer, StartPreamble, StartSFD, StartDA, StartSA} = '0;
    {StartLength, StartFCS, StartJam, StartBackoff} = '0;
    StartData = 2'b00;
  endtask

  function automatic int thr(input int fl, input logic crc);
    int t;
    t = 2 * fl - 1 - (crc ? 8 : 0);
    if (t < 0) t = 0;
    return t & 16'hFFFF;
  endfunction

  function automatic logic in_frame();
    return StateDA || StateSA || StateLength || (StateData != 2'b00) || StatePAD || StateFCS;
  endfunction

  // Next counter values from the current counts and the strobes of this cycle.
  task automatic model_step();
    logic nclr, ninc, fr, bclr, binc;
    int o_nib, o_frm;
    o_nib = m_nib;
    o_frm = m_frm;
    fr    = in_frame();
    nclr  = StartIPG || StartDefer || StartPreamble || StartSFD || StartDA || StartSA ||
            StartLength || StartFCS || StartJam || StartBackoff || StateIdle ||
            (StateLength && StartData[0]);
    ninc  = StateIPG || StatePreamble || StateSFD || fr || StateJam || StateBackOff || StateDefer;
    if (nclr) m_nib = 0;
    else if (ninc && !(StateDefer && !ExDfrEn && o_nib == MAX_DEFER_NIB_DEF)) m_nib = (o_nib + 1) % 65536;
    if (StartSFD) m_frm = 0;
    else if (fr && o_frm < 65535) m_frm = o_frm + 1;
    bclr = StartSFD || StartBackoff;
    binc = (fr && (o_frm % 2 == 1)) || (StateBackOff && (o_nib % 128 == 127));
    if (bclr) m_byt = 0;
    else if (binc && m_byt < 65535) m_byt = m_byt + 1;
  endtask

  task automatic check_all(input string tag);
    logic e_maxf, e_big, e_exd;
    e_maxf = !HugEn && (StateData != 2'b00) && (m_frm == thr(MaxFL, CrcEn));
    e_big  = !HugEn && (m_frm == ((2 * int'(MaxFL) - 1) & 16'hFFFF)) &&
             ((StateData != 2'b00) || StatePAD || StateFCS);
    e_exd  = StateDefer && !ExDfrEn && (m_nib == MAX_DEFER_NIB_DEF);
    chk({tag, ".nib"},  NibCnt,         m_nib);
    chk({tag, ".frm"},  FrmNibCnt,      m_frm);
    chk({tag, ".byte"}, ByteCnt,        m_byt);
    chk({tag, ".eq7"},  NibCntEq7,      (m_nib % 128) == 7);
    chk({tag, ".eq15"}, NibCntEq15,     (m_nib % 128) == 15);
    chk({tag, ".minfl"},NibbleMinFl,    m_frm >= thr(MinFL, CrcEn));
    chk({tag, ".maxfr"},MaxFrame,       e_maxf);
    chk({tag, ".big"},  TooBig,         e_big);
    chk({tag, ".exd"},  ExcessiveDefer, e_exd);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge MTxClk);
    #1;
    check_all(tag);
    if (min_at < 0 && NibbleMinFl) min_at = m_frm;
    if (!seen_maxf && MaxFrame) begin seen_maxf = 1; maxf_at = m_frm; end
    if (!seen_big && TooBig) begin seen_big = 1; big_at = m_frm; end
    if (!seen_exd && ExcessiveDefer) begin seen_exd = 1; exd_at = m_nib; end
  endtask

  task automatic clear_marks();
    min_at = -1; maxf_at = -1; big_at = -1; exd_at = -1;
    seen_maxf = 0; seen_big = 0; seen_exd = 0;
  endtask

  // SFD strobe, DA/SA/Length headers, then data nibbles until FrmNibCnt == target.
  task automatic walk_frame(input int target, input string tag);
    clear_marks();
    idle_inputs(); StartSFD = 1'b1; tick(tag);
    idle_inputs(); StateDA = 1'b1;
    for (int i = 0; i < ADDR_NIB; i++) tick(tag);
    idle_inputs(); StateSA = 1'b1;
    for (int i = 0; i < ADDR_NIB; i++) tick(tag);
    idle_inputs(); StateLength = 1'b1;
    for (int i = 0; i < LEN_NIB; i++) tick(tag);
    chk({tag, ".byte_hdr"}, ByteCnt, 14);
    while (m_frm < target) begin
      idle_inputs();
      StateData = (m_frm % 2 == 0) ? 2'b01 : 2'b10;
      tick(tag);
    end
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1; CrcEn = 1'b1; HugEn = 1'b0; ExDfrEn = 1'b0;
    MinFL = 16'd64; MaxFL = 16'd1518;
    m_nib = 0; m_frm = 0; m_byt = 0;
    clear_marks();
    repeat (2) @(posedge MTxClk);
    #1;
    check_all("reset");
    Reset = 1'b0;

    // Preamble section count and Eq7 position
    idle_inputs(); StartPreamble = 1'b1; tick("pre");
    idle_inputs(); StatePreamble = 1'b1;
    for (int i = 0; i < PREAMBLE_NIB; i++) begin
      chk("pre.step", NibCnt, i);
      chk("pre.eq7", NibCntEq7, i == 7);
      tick("pre");
    end

    // Async reset mid-frame
    walk_frame(40, "rstf");
    chk("rstf.frm40", FrmNibCnt, 40);
    #3 Reset = 1'b1;
    #1;
    chk("arst.nib", NibCnt, 0);
    chk("arst.frm", FrmNibCnt, 0);
    chk("arst.byte", ByteCnt, 0);
    m_nib = 0; m_frm = 0; m_byt = 0;
    check_all("arst");
    @(posedge MTxClk); #1;
    check_all("arst_hold");
    Reset = 1'b0;

    // Minimum length, CRC on then off
    CrcEn = 1'b1; MinFL = 16'd64;
    walk_frame(125, "minc");
    chk("minc.rise", min_at, 119);
    CrcEn = 1'b0;
    walk_frame(130, "minn");
    chk("minn.rise", min_at, 127);

    // Maximum length and absolute limit
    CrcEn = 1'b1; HugEn = 1'b0; MaxFL = 16'd1518;
    walk_frame(3036, "max");
    chk("max.maxframe_at", maxf_at, 3027);
    chk("max.toobig_at", big_at, 3035);
    HugEn = 1'b1;
    walk_frame(3036, "hug");
    chk("hug.maxframe_seen", seen_maxf, 0);
    chk("hug.toobig_seen", seen_big, 0);
    HugEn = 1'b0;

    // Jam strobe on a data nibble, then Jam
    walk_frame(60, "jam");
    StartJam = 1'b1; tick("jam");
    chk("jam.nib_clr", NibCnt, 0);
    idle_inputs(); StateJam = 1'b1;
    for (int i = 0; i < 8; i++) tick("jam");
    chk("jam.frm_hold", FrmNibCnt, 61);
    chk("jam.byte_hold", ByteCnt, 30);
    chk("jam.nib", NibCnt, 8);

    // Excessive defer, then defer allowed
    clear_marks(); ExDfrEn = 1'b0;
    idle_inputs(); StartDefer = 1'b1; tick("dfr");
    idle_inputs(); StateDefer = 1'b1;
    for (int i = 0; i < 6100; i++) tick("dfr");
    chk("dfr.rise_at", exd_at, 6071);
    chk("dfr.nib_frozen", NibCnt, 6071);
    chk("dfr.flag_held", ExcessiveDefer, 1);
    clear_marks(); ExDfrEn = 1'b1;
    idle_inputs(); StartDefer = 1'b1; tick("dfe");
    idle_inputs(); StateDefer = 1'b1;
    for (int i = 0; i < 6072; i++) tick("dfe");
    chk("dfe.flag_seen", seen_exd, 0);
    chk("dfe.nib", NibCnt, 6072);

    // Backoff slot ticks
    idle_inputs(); StartBackoff = 1'b1; tick("bo");
    idle_inputs(); StateBackOff = 1'b1;
    for (int i = 0; i < 256; i++) tick("bo");
    chk("bo.slots", ByteCnt, 2);

    // Randomized strobes with small frame limits so decodes toggle
    for (int c = 0; c < 3000; c++) begin
      int s;
      if (c % 200 == 0) begin
        CrcEn = 1'($urandom_range(0, 1));
        HugEn = 1'($urandom_range(0, 1));
        ExDfrEn = 1'($urandom_range(0, 1));
        MinFL = 16'($urandom_range(0, 20));
        MaxFL = 16'($urandom_range(0, 20));
      end
      idle_inputs();
      s = $urandom_range(0, 14);
      case (s)
        0: StateIdle = 1'b1;
        1: StateIPG = 1'b1;
        2: StatePreamble = 1'b1;
        3: StateSFD = 1'b1;
        4: StateDA = 1'b1;
        5: StateSA = 1'b1;
        6: StateLength = 1'b1;
        7: StateData = 2'b01;
        8: StateData = 2'b10;
        9: StatePAD = 1'b1;
        10: StateFCS = 1'b1;
        11: StateJam = 1'b1;
        12: StateBackOff = 1'b1;
        13: StateDefer = 1'b1;
        default: ;
      endcase
      StartIPG      = ($urandom_range(0, 31) == 0);
      StartDefer    = ($urandom_range(0, 31) == 0);
      StartPreamble = ($urandom_range(0, 31) == 0);
      StartSFD      = ($urandom_range(0, 31) == 0);
      StartDA       = ($urandom_range(0, 31) == 0);
      StartSA       = ($urandom_range(0, 31) == 0);
      StartLength   = ($urandom_range(0, 31) == 0);
      StartFCS      = ($urandom_range(0, 31) == 0);
      StartJam      = ($urandom_range(0, 31) == 0);
      StartBackoff  = ($urandom_range(0, 31) == 0);
      StartData     = 2'($urandom_range(0, 3) & (($urandom_range(0, 3) == 0) ? 3 : 0));
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
